// File: rtl/rtc_pkg.sv
// Shared constants, load-command payload and BCD helpers for the time-of-day counter.
package rtc_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HOUR = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;
    localparam logic [1:0] SEL_SEC  = 2'b11;

    localparam logic [7:0] BCD_MAX_MS  = 8'h59;
    localparam logic [7:0] BCD_MAX_H24 = 8'h23;
    localparam logic [7:0] BCD_MAX_H12 = 8'h12;
    localparam logic [7:0] BCD_NOON    = 8'h12;

    // Decoded, already-validated load request; val is in internal 24 h form
    typedef struct packed {
        logic       hour;
        logic       min;
        logic       sec;
        logic       err;
        logic [7:0] val;
    } load_cmd_t;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // PM hour 01..11 to 24 h; 08/09 cross a decade so they need a +6 decimal adjust
    function automatic logic [7:0] h12_pm_to_h24(input logic [7:0] h);
        if ((h[7:4] == 4'd0) && (h[3:0] >= 4'd8)) begin
            return h + 8'h18;
        end
        return h + 8'h12;
    endfunction

    function automatic logic [7:0] h24_to_h12(input logic [7:0] h);
        if (h == 8'h00) begin
            return BCD_MAX_H12;
        end
        if (h <= BCD_NOON) begin
            return h;
        end
        if (h <= 8'h19) begin
            return h - 8'h12;
        end
        if (h <= 8'h21) begin
            return h - 8'h18;
        end
        return h - 8'h12;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter (00..MAX_BCD) with load priority and a wrap carry.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] r_value;
    logic       w_at_max;

    assign w_at_max = (r_value == MAX_BCD);
    assign carry    = inc && !load && w_at_max;
    assign value    = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'h00;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            r_value <= w_at_max ? 8'h00 : bcd_inc(r_value);
        end
    end

endmodule

// File: rtl/rtc_bcd_counter.sv
// Time-of-day counter: 1 Hz prescaler, BCD h24/min/sec chain, validated loads
// and a combinational 12 h / 24 h hour display.
module rtc_bcd_counter
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000,
    parameter int unsigned DIV_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       load_en,
    input  logic [1:0] load_sel,
    input  logic [7:0] load_val,
    input  logic       load_pm,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_presc;
    logic             r_sec_pulse;
    logic             r_day_pulse;
    logic             r_load_err;

    logic             w_tick;
    logic             w_adv;
    logic             w_load_any;
    logic             w_hour_ok;
    logic             w_ms_ok;
    logic [7:0]       w_hour_24;
    load_cmd_t        w_cmd;

    logic [7:0]       w_h24;
    logic [7:0]       w_min;
    logic [7:0]       w_sec;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_day_carry;

    // Load validation and 12 h -> 24 h conversion of hour loads
    always_comb begin
        w_cmd     = '0;
        w_hour_24 = load_val;
        w_ms_ok   = bcd_valid(load_val) && (load_val <= BCD_MAX_MS);
        if (mode_12h) begin
            w_hour_ok = bcd_valid(load_val) && (load_val != 8'h00) && (load_val <= BCD_MAX_H12);
            if (load_val == BCD_NOON) begin
                w_hour_24 = load_pm ? BCD_NOON : 8'h00;
            end else if (load_pm) begin
                w_hour_24 = h12_pm_to_h24(load_val);
            end
        end else begin
            w_hour_ok = bcd_valid(load_val) && (load_val <= BCD_MAX_H24);
        end

        if (load_en) begin
            case (load_sel)
                SEL_HOUR: begin
                    w_cmd.hour = w_hour_ok;
                    w_cmd.err  = !w_hour_ok;
                    w_cmd.val  = w_hour_24;
                end
                SEL_MIN: begin
                    w_cmd.min = w_ms_ok;
                    w_cmd.err = !w_ms_ok;
                    w_cmd.val = load_val;
                end
                SEL_SEC: begin
                    w_cmd.sec = w_ms_ok;
                    w_cmd.err = !w_ms_ok;
                    w_cmd.val = load_val;
                end
                default: w_cmd = '0;
            endcase
        end
    end

    assign w_load_any = w_cmd.hour || w_cmd.min || w_cmd.sec;
    assign w_tick     = run && (r_presc == PRESC_LAST);
    // A valid load swallows a coincident tick so the loaded value is not bumped
    assign w_adv      = w_tick && !w_load_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_load_any || w_tick) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_MS)
    ) u_sec (
        .clk      (clk),
        .rst_n    (reset_n),
        .inc      (w_adv),
        .load     (w_cmd.sec),
        .load_val (w_cmd.val),
        .value    (w_sec),
        .carry    (w_sec_carry)
    );

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_MS)
    ) u_min (
        .clk      (clk),
        .rst_n    (reset_n),
        .inc      (w_sec_carry),
        .load     (w_cmd.min),
        .load_val (w_cmd.val),
        .value    (w_min),
        .carry    (w_min_carry)
    );

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_H24)
    ) u_hour (
        .clk      (clk),
        .rst_n    (reset_n),
        .inc      (w_min_carry),
        .load     (w_cmd.hour),
        .load_val (w_cmd.val),
        .value    (w_h24),
        .carry    (w_day_carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= w_adv;
            r_day_pulse <= w_day_carry;
            r_load_err  <= w_cmd.err;
        end
    end

    assign sec_pulse = r_sec_pulse;
    assign day_pulse = r_day_pulse;
    assign load_err  = r_load_err;

    assign pm   = (w_h24 >= BCD_NOON);
    assign hour = mode_12h ? h24_to_h12(w_h24) : w_h24;
    assign min  = w_min;
    assign sec  = w_sec;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Scoreboard bench for rtc_bcd_counter with CLK_DIV=4: per-scenario stimulus tables.
module tb_rtc_bcd_counter;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [1:0]  HR = 2'b01;
    localparam logic [1:0]  MN = 2'b10;
    localparam logic [1:0]  SC = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_sel = 2'b00;
    logic [7:0] load_val = 8'h00;
    logic       load_pm = 1'b0;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;
    logic       load_err;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       pm;
        logic       sp;
        logic       dp;
        logic       le;
    } snap_t;

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic [7:0] val;
        logic       lpm;
        logic       r;
        logic       md;
        logic       adv;
        snap_t      e;
    } stim_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    rtc_bcd_counter #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .mode_12h  (mode_12h),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_val  (load_val),
        .load_pm   (load_pm),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .pm        (pm),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    function automatic snap_t S(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic p, input logic sp, input logic dp, input logic le);
        return {h, m, s, p, sp, dp, le};
    endfunction

    function automatic stim_t mk(input logic en, input logic [1:0] sel, input logic [7:0] val,
                                 input logic lpm, input logic r, input logic md,
                                 input logic adv, input snap_t e);
        return {en, sel, val, lpm, r, md, adv, e};
    endfunction

    function automatic stim_t idle(input logic r, input logic md, input snap_t e);
        return mk(1'b0, 2'b00, 8'h00, 1'b0, r, md, 1'b1, e);
    endfunction

    function automatic stim_t look(input logic r, input logic md, input snap_t e);
        return mk(1'b0, 2'b00, 8'h00, 1'b0, r, md, 1'b0, e);
    endfunction

    function automatic stim_t ld(input logic [1:0] sel, input logic [7:0] val, input logic lpm,
                                 input logic r, input logic md, input snap_t e);
        return mk(1'b1, sel, val, lpm, r, md, 1'b1, e);
    endfunction

    function automatic snap_t observe();
        return {hour, min, sec, pm, sec_pulse, day_pulse, load_err};
    endfunction

    function automatic string fmt(input snap_t v);
        return $sformatf("%h:%h:%h pm=%b sp=%b dp=%b le=%b", v.h, v.m, v.s, v.pm, v.sp, v.dp, v.le);
    endfunction

    task automatic drive(input stim_t t);
        load_en  = t.en;
        load_sel = t.sel;
        load_val = t.val;
        load_pm  = t.lpm;
        run      = t.r;
        mode_12h = t.md;
        if (t.adv) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        run      = 1'b0;
        load_en  = 1'b0;
        load_sel = 2'b00;
        load_val = 8'h00;
        load_pm  = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t got;
        snap_t exp;
        #2;
        reset_n = 1'b0;
        for (int md = 0; md < 2; md++) begin
            mode_12h = 1'(md);
            exp_q.push_back(md == 1 ? S(8'h12, 8'h00, 8'h00, 0, 0, 0, 0) : S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
            #1;
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset[%0d] got %s expected %s", md, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_first_second();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 1, 0, 0)));
        t.push_back(idle(1, 1, S(8'h12, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h02, 0, 1, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL first_second[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_day_wrap();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        t.push_back(ld(HR, 8'h23, 0, 1, 0, S(8'h23, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(MN, 8'h59, 0, 1, 0, S(8'h23, 8'h59, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(SC, 8'h58, 0, 1, 0, S(8'h23, 8'h59, 8'h58, 1, 0, 0, 0)));
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h23, 8'h59, 8'h58, 1, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h23, 8'h59, 8'h59, 1, 1, 0, 0)));
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h23, 8'h59, 8'h59, 1, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 1, 1, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL day_wrap[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        load_en = 1'b0;
    endtask

    task automatic test_12h_load();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        t.push_back(ld(HR, 8'h12, 0, 0, 1, S(8'h12, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(HR, 8'h07, 1, 0, 1, S(8'h07, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h19, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(HR, 8'h12, 1, 0, 1, S(8'h12, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h12, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(HR, 8'h11, 1, 0, 1, S(8'h11, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h23, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(HR, 8'h09, 1, 0, 1, S(8'h09, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h21, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(HR, 8'h08, 1, 0, 1, S(8'h08, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h20, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(HR, 8'h00, 0, 0, 1, S(8'h08, 8'h00, 8'h00, 1, 0, 0, 1)));
        t.push_back(ld(HR, 8'h13, 1, 0, 1, S(8'h08, 8'h00, 8'h00, 1, 0, 0, 1)));
        t.push_back(ld(HR, 8'h1A, 0, 0, 1, S(8'h08, 8'h00, 8'h00, 1, 0, 0, 1)));
        t.push_back(ld(HR, 8'h01, 0, 0, 1, S(8'h01, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(HR, 8'h10, 0, 0, 1, S(8'h10, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(look(0, 0, S(8'h10, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(HR, 8'h12, 0, 0, 0, S(8'h12, 8'h00, 8'h00, 1, 0, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL load_12h[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        load_en = 1'b0;
    endtask

    task automatic test_invalid_loads();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        t.push_back(ld(MN, 8'h60, 0, 1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 1)));
        t.push_back(ld(MN, 8'h5A, 0, 1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 1)));
        t.push_back(ld(HR, 8'h24, 0, 1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 1)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 1, 0, 0)));
        t.push_back(ld(2'b00, 8'h45, 0, 1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(ld(SC, 8'hA0, 0, 1, 0, S(8'h00, 8'h00, 8'h02, 0, 1, 0, 1)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h02, 0, 0, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL invalid_load[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        load_en = 1'b0;
    endtask

    task automatic test_load_on_tick();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(SC, 8'h30, 0, 1, 0, S(8'h00, 8'h00, 8'h30, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h30, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h31, 0, 1, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL load_on_tick[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        load_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        snap_t got;
        snap_t exp;
        do_reset();
        t.push_back(ld(HR, 8'h09, 0, 1, 0, S(8'h09, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(MN, 8'h59, 0, 1, 0, S(8'h09, 8'h59, 8'h00, 0, 0, 0, 0)));
        t.push_back(ld(SC, 8'h59, 0, 1, 0, S(8'h09, 8'h59, 8'h59, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h09, 8'h59, 8'h59, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h10, 8'h00, 8'h00, 0, 1, 0, 0)));
        t.push_back(ld(HR, 8'h19, 0, 1, 0, S(8'h19, 8'h00, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(MN, 8'h59, 0, 1, 1, S(8'h07, 8'h59, 8'h00, 1, 0, 0, 0)));
        t.push_back(ld(SC, 8'h59, 0, 1, 1, S(8'h07, 8'h59, 8'h59, 1, 0, 0, 0)));
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 1, S(8'h07, 8'h59, 8'h59, 1, 0, 0, 0)));
        t.push_back(idle(1, 1, S(8'h08, 8'h00, 8'h00, 1, 1, 0, 0)));
        t.push_back(look(1, 0, S(8'h20, 8'h00, 8'h00, 1, 1, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        load_en = 1'b0;
    endtask

    task automatic test_pause_reset();
        stim_t t[$];
        stim_t u[$];
        snap_t got;
        snap_t exp;
        do_reset();
        for (int i = 0; i < 3; i++) t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 1, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        for (int i = 0; i < 10; i++) t.push_back(idle(0, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 0, 0, 0)));
        t.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h02, 0, 1, 0, 0)));
        foreach (t[i]) begin
            exp_q.push_back(t[i].e);
            drive(t[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL pause[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end

        // Reset asserted between edges while sec_pulse is high
        #2;
        reset_n = 1'b0;
        exp_q.push_back(S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
        #1;
        got = observe();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL async_reset got %s expected %s", fmt(got), fmt(exp));
        end
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) u.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h00, 0, 0, 0, 0)));
        u.push_back(idle(1, 0, S(8'h00, 8'h00, 8'h01, 0, 1, 0, 0)));
        foreach (u[i]) begin
            exp_q.push_back(u[i].e);
            drive(u[i]);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL after_reset[%0d] got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t with checks=%0d", $time, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_second();
        test_day_wrap();
        test_12h_load();
        test_invalid_loads();
        test_load_on_tick();
        test_back_to_back();
        test_pause_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
